// File: rtl/register_bank.sv
// General-purpose register file on the write-back path: two bypassed read ports,
// one write port, and a sequential engine that streams every register to the debug unit.
module register_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_WIDTH-1:0] i_readreg1,
   input  logic [ADDR_WIDTH-1:0] i_readreg2,
   input  logic [ADDR_WIDTH-1:0] i_writereg,
   input  logic [DATA_WIDTH-1:0] i_writedata,
   input  logic                  i_regwrite,
   output logic [DATA_WIDTH-1:0] o_data1,
   output logic [DATA_WIDTH-1:0] o_data2,
   input  logic                  i_dump_start,
   input  logic                  i_dump_ready,
   output logic                  o_dump_valid,
   output logic [ADDR_WIDTH-1:0] o_dump_index,
   output logic [DATA_WIDTH-1:0] o_dump_data,
   output logic                  o_dump_busy,
   output logic                  o_dump_done
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } dump_state_t;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   dump_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;

   logic write_en;
   assign write_en = i_regwrite && (i_writereg != '0);

   // NOTE: the register array is cleared on reset on purpose; software relies on
   // every GPR reading zero afterwards, so this is a flop array, not a RAM macro.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            // NOTE: non-blocking assignments for all sequential state, so every
            // flop samples pre-edge values regardless of statement order.
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[i_writereg] <= i_writedata;
      end
   end

   // regs[0] is never written, so it reads as zero; write_en also excludes index 0
   // from the bypass path.
   always_comb begin
      // NOTE: default first, then override, so no path leaves the output unassigned
      // and no latch is inferred.
      o_data1 = regs[i_readreg1];
      if (write_en && (i_writereg == i_readreg1)) begin
         o_data1 = i_writedata;
      end
   end

   always_comb begin
      o_data2 = regs[i_readreg2];
      if (write_en && (i_writereg == i_readreg2)) begin
         o_data2 = i_writedata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (i_dump_start) begin
               state_d = DUMP;
               idx_d   = '0;
            end
         end
         DUMP: begin
            if (i_dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + ADDR_WIDTH'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Dump data comes straight from storage: a same-cycle write shows up in later words only.
   assign o_dump_valid = (state_q == DUMP);
   assign o_dump_busy  = (state_q != IDLE);
   assign o_dump_done  = (state_q == DONE);
   assign o_dump_index = idx_q;
   assign o_dump_data  = regs[idx_q];

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: reset state, bypass, r0 handling, full dumps
// with steady and throttled ready, and reset in the middle of a dump.
module tb_register_bank;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic [AW-1:0] i_readreg1, i_readreg2, i_writereg;
   logic [DW-1:0] i_writedata;
   logic          i_regwrite;
   logic [DW-1:0] o_data1, o_data2;
   logic          i_dump_start, i_dump_ready;
   logic          o_dump_valid;
   logic [AW-1:0] o_dump_index;
   logic [DW-1:0] o_dump_data;
   logic          o_dump_busy, o_dump_done;

   int checks = 0;
   int errors = 0;

   register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_readreg1  (i_readreg1),
      .i_readreg2  (i_readreg2),
      .i_writereg  (i_writereg),
      .i_writedata (i_writedata),
      .i_regwrite  (i_regwrite),
      .o_data1     (o_data1),
      .o_data2     (o_data2),
      .i_dump_start(i_dump_start),
      .i_dump_ready(i_dump_ready),
      .o_dump_valid(o_dump_valid),
      .o_dump_index(o_dump_index),
      .o_dump_data (o_dump_data),
      .o_dump_busy (o_dump_busy),
      .o_dump_done (o_dump_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] exp_data;
      int            exp_idx;
      bit            done_seen;
      bit            hit;
      bit            ready_pat [4];

      ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};

      i_reset      = 1'b1;
      i_readreg1   = '0;
      i_readreg2   = '0;
      i_writereg   = '0;
      i_writedata  = '0;
      i_regwrite   = 1'b0;
      i_dump_start = 1'b0;
      i_dump_ready = 1'b0;
      tick();
      tick();
      i_reset = 1'b0;

      // Reset state on both ports and on the dump interface.
      for (int k = 0; k < 32; k++) begin
         i_readreg1 = AW'(k);
         i_readreg2 = AW'(31 - k);
         #1;
         check($sformatf("rst_rd1_%0d", k), o_data1, '0);
         check($sformatf("rst_rd2_%0d", 31 - k), o_data2, '0);
      end
      check("rst_valid", DW'(o_dump_valid), '0);
      check("rst_busy", DW'(o_dump_busy), '0);
      check("rst_done", DW'(o_dump_done), '0);
      check("rst_index", DW'(o_dump_index), '0);
      check("rst_ddata", o_dump_data, '0);

      // Same-cycle bypass, then the stored value.
      tick();
      i_regwrite  = 1'b1;
      i_writereg  = 5'd5;
      i_writedata = 32'hDEADBEEF;
      i_readreg1  = 5'd5;
      #1;
      check("bypass_rd1", o_data1, 32'hDEADBEEF);
      tick();
      i_regwrite = 1'b0;
      #1;
      check("stored_rd1", o_data1, 32'hDEADBEEF);

      // Writes to r0 are dropped, with and without bypass.
      tick();
      i_regwrite  = 1'b1;
      i_writereg  = 5'd0;
      i_writedata = 32'h12345678;
      i_readreg2  = 5'd0;
      #1;
      check("r0_bypass_rd2", o_data2, '0);
      tick();
      i_regwrite = 1'b0;
      #1;
      check("r0_after_rd2", o_data2, '0);

      // Both ports bypass the same register at once.
      i_regwrite  = 1'b1;
      i_writereg  = 5'd7;
      i_writedata = 32'h0BADF00D;
      i_readreg1  = 5'd7;
      i_readreg2  = 5'd7;
      #1;
      check("dual_bypass_rd1", o_data1, 32'h0BADF00D);
      check("dual_bypass_rd2", o_data2, 32'h0BADF00D);

      // Load regs[k] = k*0x10.
      for (int k = 1; k < 32; k++) begin
         tick();
         i_regwrite  = 1'b1;
         i_writereg  = AW'(k);
         i_writedata = DW'(k * 16);
      end
      tick();
      i_regwrite = 1'b0;
      for (int k = 0; k < 32; k++) begin
         i_readreg2 = AW'(k);
         #1;
         check($sformatf("load_rd2_%0d", k), o_data2, DW'(k * 16));
      end

      // Full dump with ready held high: 32 beats, then one DONE cycle.
      i_dump_start = 1'b1;
      i_dump_ready = 1'b1;
      tick();
      i_dump_start = 1'b0;
      for (int b = 0; b < 32; b++) begin
         #1;
         check($sformatf("dump_valid_%0d", b), DW'(o_dump_valid), 32'd1);
         check($sformatf("dump_index_%0d", b), DW'(o_dump_index), DW'(b));
         check($sformatf("dump_data_%0d", b), o_dump_data, DW'(b * 16));
         check($sformatf("dump_done_%0d", b), DW'(o_dump_done), '0);
         tick();
      end
      #1;
      check("done_pulse", DW'(o_dump_done), 32'd1);
      check("done_valid", DW'(o_dump_valid), '0);
      check("done_busy", DW'(o_dump_busy), 32'd1);
      tick();
      check("idle_done", DW'(o_dump_done), '0);
      check("idle_busy", DW'(o_dump_busy), '0);
      check("idle_valid", DW'(o_dump_valid), '0);

      // Throttled dump; r31 rewritten mid-dump must appear in the last beat.
      i_dump_start = 1'b1;
      tick();
      i_dump_start = 1'b0;
      exp_idx   = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         i_dump_ready = ready_pat[c % 4];
         i_regwrite   = (c == 10);
         i_writereg   = 5'd31;
         i_writedata  = 32'hA5A5A5A5;
         #1;
         if (o_dump_done) begin
            done_seen = 1'b1;
            break;
         end
         if (o_dump_valid && i_dump_ready) begin
            exp_data = (exp_idx == 31) ? 32'hA5A5A5A5 : DW'(exp_idx * 16);
            check($sformatf("thr_index_%0d", exp_idx), DW'(o_dump_index), DW'(exp_idx));
            check($sformatf("thr_data_%0d", exp_idx), o_dump_data, exp_data);
            exp_idx++;
         end
         tick();
      end
      i_regwrite = 1'b0;
      check("thr_beats", DW'(exp_idx), 32'd32);
      check("thr_done_seen", DW'(done_seen), 32'd1);
      tick();
      check("thr_idle_busy", DW'(o_dump_busy), '0);

      // Reset at index 10 of a dump; a write in the reset cycle is dropped too.
      i_dump_start = 1'b1;
      i_dump_ready = 1'b1;
      tick();
      i_dump_start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (o_dump_valid && o_dump_index == 5'd10) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      check("mid_reached_10", DW'(hit), 32'd1);
      i_reset     = 1'b1;
      i_regwrite  = 1'b1;
      i_writereg  = 5'd3;
      i_writedata = 32'hFFFF_FFFF;
      tick();
      i_reset    = 1'b0;
      i_regwrite = 1'b0;
      #1;
      check("mid_valid", DW'(o_dump_valid), '0);
      check("mid_busy", DW'(o_dump_busy), '0);
      check("mid_index", DW'(o_dump_index), '0);
      check("mid_done", DW'(o_dump_done), '0);
      check("mid_ddata", o_dump_data, '0);
      tick();
      check("mid_done_next", DW'(o_dump_done), '0);
      for (int k = 0; k < 32; k++) begin
         i_readreg1 = AW'(k);
         #1;
         check($sformatf("mid_rd1_%0d", k), o_data1, '0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Receiving end of the write-back path: holds the 32 GPRs and accepts the WB-stage result on its write port.
- Serves two combinational read ports to ID, with write-first bypass so a same-cycle WB write is visible to the instruction being decoded.
- Includes a sequential dump engine that streams every register to the debug unit over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH

Ports:
- i_clk  input  1  system clock, rising edge
- i_reset  input  1  synchronous, active-high reset
- i_readreg1  input  ADDR_WIDTH  read port 1 index (rs)
- i_readreg2  input  ADDR_WIDTH  read port 2 index (rt)
- i_writereg  input  ADDR_WIDTH  write index from WB
- i_writedata  input  DATA_WIDTH  write data from WB (mem/alu/return-address result)
- i_regwrite  input  1  write enable from WB
- o_data1  output  DATA_WIDTH  read port 1 data
- o_data2  output  DATA_WIDTH  read port 2 data
- i_dump_start  input  1  request full register dump (level or pulse; sampled in IDLE only)
- i_dump_ready  input  1  debug unit accepts current dump word
- o_dump_valid  output  1  dump word valid
- o_dump_index  output  ADDR_WIDTH  index of current dump word
- o_dump_data  output  DATA_WIDTH  contents of register o_dump_index
- o_dump_busy  output  1  dump in progress (DUMP or DONE)
- o_dump_done  output  1  one-cycle pulse after last word is accepted

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset: all registers 0. FSM goes to IDLE with index 0. o_dump_valid, o_dump_busy and o_dump_done are 0. o_dump_index is 0. o_dump_data is 0.
- Register 0 is hardwired to zero. Writes to index 0 are discarded, and reads of index 0 always return 0, including under bypass.
- Write: on the rising edge where i_regwrite=1 and i_writereg!=0, regs[i_writereg] <= i_writedata. Latency 1 cycle to storage.
- Read (combinational, 0 latency): o_dataN = i_writedata if i_regwrite && i_writereg==i_readregN && i_writereg!=0; otherwise o_dataN = regs[i_readregN].
- Both read ports may address the same register, and both may bypass at once.
- i_reset=1 overrides a write in the same cycle.
- Dump FSM has three states: IDLE, DUMP, DONE.
  - IDLE: if i_dump_start=1, move to DUMP with idx=0. Otherwise stay.
  - DUMP: o_dump_valid=1, o_dump_index=idx, o_dump_data=regs[idx] taken from storage (no bypass; a write in the same cycle appears in later words only).
  - DUMP: a transfer occurs when valid && i_dump_ready. On a transfer with idx<NUM_REGS-1, idx increments. On a transfer with idx==NUM_REGS-1, move to DONE. Without i_dump_ready, hold index and state; data tracks storage.
  - DONE: o_dump_done=1 for exactly one cycle, o_dump_valid=0, then return to IDLE. i_dump_start is ignored in this cycle.
- o_dump_busy=1 in DUMP and DONE.
- i_dump_start is ignored while busy, so a held start re-triggers only from IDLE, one cycle after DONE.
- Normal reads and writes are never stalled by a dump.
- Index wrap: idx never wraps past NUM_REGS-1 within a dump; a new dump restarts at 0.
- Reset mid-dump: next state IDLE, outputs at reset values, registers cleared, no done pulse.
- Total dump time with i_dump_ready held high: NUM_REGS cycles in DUMP plus 1 DONE cycle.

Test Plan:
- Reset, then read all 32 indices on both ports -> all 0; o_dump_valid=0, o_dump_busy=0, o_dump_done=0.
- Write regs[5]=0xDEADBEEF with i_readreg1=5 in the same cycle -> o_data1=0xDEADBEEF combinationally (bypass); next cycle with i_regwrite=0 -> still 0xDEADBEEF.
- Write i_writereg=0, i_writedata=0x12345678, i_readreg2=0 -> o_data2=0 in that cycle and after.
- Load regs[k]=k*0x10 for k=1..31; pulse i_dump_start with i_dump_ready=1 -> 32 consecutive valid beats, index 0..31, data 0, 0x10 … 0x1F0; then one o_dump_done pulse; busy drops after DONE.
- Dump with i_dump_ready toggling 1,0,0,1… -> index advances only on ready cycles; no words lost or repeated; write regs[31]=0xA5A5A5A5 mid-dump before index 31 -> beat 31 carries 0xA5A5A5A5.
- Assert i_reset at index 10 of a dump -> next cycle valid=0, busy=0, index=0, no done pulse; all reads return 0.
